// File: rtl/seg_scan_drv_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan driver.
//   seg_t      8-bit segment word {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp
//   SEG_A..SEG_DP  bit positions inside seg_t
//   GLYPH      16-entry hex glyph table, 7 bits {a..g} per nibble
//   SEG_OFF    all segments off (active-high sense)
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam seg_t SEG_OFF = 8'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg_scan_drv_decode.sv
// seg_hex_decode: combinational hex nibble + decimal point to segment word.
//   nib  in   4  hex digit
//   dp   in   1  decimal point
//   seg  out  8  {a..g, dp}, active-high
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output seg_t       seg
);

  always_comb begin
    seg                = SEG_OFF;
    seg[SEG_A:SEG_G]   = GLYPH[nib];
    seg[SEG_DP]        = dp;
  end

endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: time-multiplexed seven-segment driver with frame-aligned
// shadow register and optional leading-zero blanking.
//   clk         in   1            system clock
//   rst         in   1            synchronous active-high reset
//   en          in   1            scan enable; 0 = dark, counters frozen
//   load        in   1            strobe capturing value/dp into pending buffer
//   value       in   4*DIGITS     hex nibbles, value[3:0] = digit 0
//   dp          in   DIGITS       decimal points, dp[0] = digit 0
//   blank_lz    in   1            leading-zero blanking enable
//   seg_out     out  8            {a..g,dp}, polarity per ACTIVE_LOW
//   an_out      out  DIGITS       one-hot anode select, polarity per ACTIVE_LOW
//   frame_done  out  1            pulse in the first cycle a new shadow is live
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DIV        = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(DIV);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam seg_t              SEG_DARK = {8{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_DARK  = {DIGITS{ACTIVE_LOW}};

  function automatic seg_t pol_seg(input seg_t s);
    return ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [DIGITS-1:0] pol_an(input logic [DIGITS-1:0] a);
    return ACTIVE_LOW ? ~a : a;
  endfunction

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_vld;
  logic [4*DIGITS-1:0] shd_val;
  logic [DIGITS-1:0]   shd_dp;
  logic                wrap;

  assign wrap = en && (div_cnt == DIV_LAST) && (idx == IDX_LAST);

  // Scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Pending buffer and frame-aligned shadow; a load coinciding with the
  // wrap bypasses the pending buffer so it is visible in the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      shd_val  <= '0;
      shd_dp   <= '0;
    end else if (wrap) begin
      if (load) begin
        shd_val <= value;
        shd_dp  <= dp;
      end else if (pend_vld) begin
        shd_val <= pend_val;
        shd_dp  <= pend_dp;
      end
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp;
      pend_vld <= 1'b1;
    end
  end

  // Leading-zero mask: suffix-OR from the most significant nibble down.
  // Digit 0 is never blanked.
  logic [DIGITS-1:0] lz_blank;
  logic              nz_acc;

  always_comb begin
    lz_blank = '0;
    nz_acc   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc      = nz_acc | (|shd_val[4*i +: 4]);
      lz_blank[i] = (i != 0) && blank_lz && !nz_acc;
    end
  end

  // Current digit mux
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [DIGITS-1:0] an_sel;
  seg_t              dec_seg;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shd_val[4*i +: 4];
        cur_dp    = shd_dp[i];
        cur_blank = lz_blank[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  seg_hex_decode u_dec (
    .nib (cur_nib),
    .dp  (cur_dp),
    .seg (dec_seg)
  );

  // Output register stage (p1)
  seg_t              seg_p1;
  logic [DIGITS-1:0] an_p1;
  logic              fd_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1 <= SEG_DARK;
      an_p1  <= AN_DARK;
      fd_p1  <= 1'b0;
    end else begin
      fd_p1 <= wrap;
      if (en && !cur_blank) begin
        seg_p1 <= pol_seg(dec_seg);
        an_p1  <= pol_an(an_sel);
      end else begin
        seg_p1 <= SEG_DARK;
        an_p1  <= AN_DARK;
      end
    end
  end

  assign seg_out    = seg_p1;
  assign an_out     = an_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_seg_scan_drv.sv
module tb_seg_scan_drv;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;

  logic [7:0]  seg_a;
  logic [3:0]  an_a;
  logic        fd_a;
  logic [7:0]  seg_b;
  logic [3:0]  an_b;
  logic        fd_b;

  seg_scan_drv #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .seg_out(seg_a), .an_out(an_a), .frame_done(fd_a)
  );

  seg_scan_drv #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp(dp),
    .blank_lz(blank_lz), .seg_out(seg_b), .an_out(an_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    int         tag;
    logic [7:0] s;
    logic [3:0] a;
    logic       fd;
    bit         chk2;
    logic [7:0] s2;
    logic [3:0] a2;
  } exp_t;

  exp_t sbq[$];
  bit   done = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic exp1(input int tag, input logic [7:0] s, input logic [3:0] a, input logic fd);
    exp_t e;
    e.tag = tag; e.s = s; e.a = a; e.fd = fd; e.chk2 = 1'b0; e.s2 = 8'h00; e.a2 = 4'h0;
    sbq.push_back(e);
  endtask

  task automatic exp2(input int tag, input logic [7:0] s, input logic [3:0] a, input logic fd,
                      input logic [7:0] s2, input logic [3:0] a2);
    exp_t e;
    e.tag = tag; e.s = s; e.a = a; e.fd = fd; e.chk2 = 1'b1; e.s2 = s2; e.a2 = a2;
    sbq.push_back(e);
  endtask

  task automatic push_frame(input int t0, input logic [31:0] segs, input logic [15:0] ans);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++)
        exp1(t0 + 4*d + k, segs[8*d +: 8], ans[4*d +: 4], (d == 3) && (k == 3));
  endtask

  // Monitor: pops every expectation whose cycle tag has come up and compares.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    while (sbq.size() > 0 && sbq[0].tag <= ncyc) begin
      e = sbq.pop_front();
      n_tests++;
      if (e.tag < ncyc) begin
        n_fail++;
        $display("FAIL stale_expect tag=%0d now=%0d", e.tag, ncyc);
      end else begin
        ok = (seg_a === e.s) && (an_a === e.a) && (fd_a === e.fd);
        if (e.chk2) ok = ok && (seg_b === e.s2) && (an_b === e.a2);
        if (!ok)
          $display("FAIL cyc%0d got seg=%h an=%b fd=%b al_seg=%h al_an=%b want seg=%h an=%b fd=%b al_seg=%h al_an=%b (al checked=%0d)",
                   ncyc, seg_a, an_a, fd_a, seg_b, an_b, e.s, e.a, e.fd, e.s2, e.a2, e.chk2);
        if (!ok) n_fail++;
      end
    end
    if (done) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL unconsumed_expect tag=%0d now=%0d", e.tag, ncyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (ncyc < n) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0;

    // Reset hold with en high
    for (int t = 1; t <= 3; t++) exp2(t, 8'h00, 4'h0, 1'b0, 8'hFF, 4'hF);
    wait_to(3);
    rst = 1'b0;
    push_frame(4, 32'hFCFCFCFC, 16'h8421);

    // Multi-digit decode with decimal point
    wait_to(5);
    push_frame(20, 32'h60DAEE8F, 16'h8421);
    do_load(16'h12AF, 4'b0001);

    // Leading-zero blanking
    wait_to(21);
    blank_lz = 1'b1;
    push_frame(36, 32'h000000B6, 16'h0001);
    do_load(16'h0005, 4'b0000);
    wait_to(37);
    push_frame(52, 32'h000000FC, 16'h0001);
    do_load(16'h0000, 4'b0000);

    // Mid-frame loads, last wins, no tearing
    wait_to(67);
    blank_lz = 1'b0;
    push_frame(68, 32'hFCFCFCFC, 16'h8421);
    wait_to(70);
    do_load(16'h1111, 4'b0000);
    wait_to(72);
    push_frame(84, 32'hDADADADA, 16'h8421);
    do_load(16'h2222, 4'b0000);

    // Pending load overridden by a load in the wrap cycle
    wait_to(90);
    do_load(16'h4444, 4'b0000);
    wait_to(98);
    for (int t = 100; t <= 103; t++) exp1(t, 8'hF2, 4'b0001, 1'b0);
    for (int t = 104; t <= 107; t++) exp1(t, 8'hF2, 4'b0010, 1'b0);
    exp2(108, 8'hF2, 4'b0100, 1'b0, 8'h0D, 4'b1011);
    do_load(16'h3333, 4'b0000);

    // Enable dropped mid digit 2 for 10 cycles
    wait_to(108);
    en = 1'b0;
    for (int t = 109; t <= 118; t++) exp2(t, 8'h00, 4'h0, 1'b0, 8'hFF, 4'hF);
    wait_to(118);
    en = 1'b1;
    exp2(119, 8'hF2, 4'b0100, 1'b0, 8'h0D, 4'b1011);
    for (int t = 120; t <= 121; t++) exp1(t, 8'hF2, 4'b0100, 1'b0);
    for (int t = 122; t <= 125; t++) exp1(t, 8'hF2, 4'b1000, t == 125);
    for (int t = 126; t <= 129; t++) exp1(t, 8'hF2, 4'b0001, 1'b0);
    for (int t = 130; t <= 133; t++) exp1(t, 8'hF2, 4'b0010, 1'b0);

    // Reset mid-frame discards the pending value
    wait_to(130);
    do_load(16'h5555, 4'b1111);
    wait_to(133);
    rst = 1'b1;
    exp2(134, 8'h00, 4'h0, 1'b0, 8'hFF, 4'hF);
    exp2(135, 8'h00, 4'h0, 1'b0, 8'hFF, 4'hF);
    wait_to(135);
    rst = 1'b0;
    push_frame(136, 32'hFCFCFCFC, 16'h8421);
    push_frame(152, 32'hFCFCFCFC, 16'h8421);

    wait_to(170);
    done = 1'b1;
    wait_to(200);
    $display("FAIL monitor_timeout now=%0d", ncyc);
    $fatal(1, "monitor did not finish");
  end

endmodule
